// File: rtl/font_codes_pkg.sv
// Shared font character codes and the state encoding for the value-to-text converter.
package font_codes_pkg;

  typedef logic [7:0] char_code_t;

  localparam char_code_t CHAR_DIGIT_0 = 8'd0;
  localparam char_code_t CHAR_DIGIT_1 = 8'd1;
  localparam char_code_t CHAR_DIGIT_2 = 8'd2;
  localparam char_code_t CHAR_DIGIT_3 = 8'd3;
  localparam char_code_t CHAR_DIGIT_4 = 8'd4;
  localparam char_code_t CHAR_DIGIT_5 = 8'd5;
  localparam char_code_t CHAR_DIGIT_6 = 8'd6;
  localparam char_code_t CHAR_DIGIT_7 = 8'd7;
  localparam char_code_t CHAR_DIGIT_8 = 8'd8;
  localparam char_code_t CHAR_DIGIT_9 = 8'd9;
  localparam char_code_t CHAR_BLANK   = 8'd255;
  localparam char_code_t CHAR_OVF     = 8'd254;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_WRITE
  } v2c_state_t;

  // Elaboration-time 10^n, used for the largest value that fits in n digits.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/value_to_char_codes_if.sv
// Request/response and text-buffer write port of the value-to-text converter.
interface value_to_char_codes_if
  import font_codes_pkg::*;
#(
  parameter int unsigned VALUE_W = 10,
  parameter int unsigned DIGITS  = 4
);
  localparam int unsigned ADDR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic               start;
  logic [VALUE_W-1:0] value;
  logic               busy;
  logic               done;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  char_code_t         wr_data;

  modport master (
    output start, value,
    input  busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, value,
    output busy, done, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted_c
);

  assign adjusted_c = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/value_to_char_codes.sv
// Converts a binary reading to DIGITS font codes (blank leading zeros, overflow marks)
// and writes them, most significant cell first, into the text buffer.
module value_to_char_codes
  import font_codes_pkg::*;
#(
  parameter int unsigned VALUE_W    = 10,
  parameter int unsigned DIGITS     = 4,
  parameter char_code_t  BLANK_CODE = CHAR_BLANK,
  parameter char_code_t  OVF_CODE   = CHAR_OVF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  value_to_char_codes_if.slave bus
);

  localparam int unsigned     BCD_W     = 4 * DIGITS;
  localparam int unsigned     CAT_W     = BCD_W + VALUE_W;
  localparam int unsigned     ADDR_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned     CNT_W     = $clog2(VALUE_W + 1);
  localparam longint unsigned MAX_VAL   = pow10(DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(VALUE_W - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(DIGITS - 1);

  if (DIGITS < 1 || VALUE_W < 1) begin : g_param_check
    $error("value_to_char_codes: DIGITS and VALUE_W must both be at least 1");
  end

  v2c_state_t         state_q, state_d;
  logic [VALUE_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]  cell_q, cell_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  char_code_t         wr_data_q, wr_data_d;

  logic [BCD_W-1:0]   bcd_adj_c;
  logic [CAT_W-1:0]   cat_c;
  logic [BCD_W-1:0]   src_bcd_c;
  logic [3:0]         nib_c;
  logic               lead_zero_c;
  char_code_t         code_c [DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .nibble     (bcd_q[4*g +: 4]),
      .adjusted_c (bcd_adj_c[4*g +: 4])
    );
  end

  // One double-dabble step: adjusted BCD and the value shift left together.
  assign cat_c = {bcd_adj_c, shift_q} << 1;

  // The first cell is written straight off the final shift, later cells from the held result.
  assign src_bcd_c = (state_q == ST_CONVERT) ? cat_c[CAT_W-1:VALUE_W] : bcd_q;

  // Code per cell; leading zeros blank except the least significant cell.
  always_comb begin
    lead_zero_c = 1'b1;
    nib_c       = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib_c       = src_bcd_c[4*(DIGITS-1-i) +: 4];
      lead_zero_c = lead_zero_c && (nib_c == 4'd0);
      if (ovf_q) begin
        code_c[i] = OVF_CODE;
      end else if ((i < DIGITS - 1) && lead_zero_c) begin
        code_c[i] = BLANK_CODE;
      end else begin
        code_c[i] = {4'b0000, nib_c};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    cell_d    = cell_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shift_d   = bus.value;
          bcd_d     = '0;
          bit_cnt_d = '0;
          ovf_d     = (64'(bus.value) > MAX_VAL);
          state_d   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        bcd_d     = cat_c[CAT_W-1:VALUE_W];
        shift_d   = cat_c[VALUE_W-1:0];
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = ST_WRITE;
          cell_d    = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = code_c[0];
        end
      end
      ST_WRITE: begin
        if (cell_q == LAST_CELL) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cell_d    = cell_q + ADDR_W'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = cell_d;
          wr_data_d = code_c[cell_d];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      cell_q    <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      cell_q    <= cell_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_value_to_char_codes.sv
// Bench for value_to_char_codes: a 4-digit and a 3-digit instance checked every cycle
// against a timeline model built from decimal arithmetic, plus literal write-sequence checks.
module tb_value_to_char_codes;
  import font_codes_pkg::*;

  localparam int unsigned VW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  value_to_char_codes_if #(.VALUE_W(VW), .DIGITS(4)) bus4 ();
  value_to_char_codes_if #(.VALUE_W(VW), .DIGITS(3)) bus3 ();

  value_to_char_codes #(.VALUE_W(VW), .DIGITS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  value_to_char_codes #(.VALUE_W(VW), .DIGITS(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Expected timeline, keyed by cycle*2 + dut (0 = 4 digits, 1 = 3 digits).
  int  m_addr [int];
  int  m_data [int];
  bit  m_busy [int];
  bit  m_done [int];
  int  free_at [2];

  int log4 [$];
  int wcyc4 [$];
  int log3 [$];
  int done_cyc4 = -1;
  int ndone4 = 0;
  int nbusy4 = 0;

  function automatic int key(int d, int c);
    return c * 2 + d;
  endfunction

  function automatic int pow10i(int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Character code for cell idx of value v shown in nd decimal cells.
  function automatic int model_code(int v, int nd, int idx);
    int p;
    p = pow10i(nd - 1 - idx);
    if (v > pow10i(nd) - 1) return 254;
    if (idx < nd - 1 && v < p) return 255;
    return (v / p) % 10;
  endfunction

  task automatic chk(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic model_accept(int d, bit st, int v);
    int c, nd;
    c  = cyc;
    nd = (d == 0) ? 4 : 3;
    if (st && c >= free_at[d]) begin
      for (int i = 0; i < nd; i++) begin
        m_addr[key(d, c + VW + 1 + i)] = i;
        m_data[key(d, c + VW + 1 + i)] = model_code(v, nd, i);
      end
      for (int b = c + 1; b <= c + VW + nd; b++) m_busy[key(d, b)] = 1'b1;
      m_done[key(d, c + VW + nd + 1)] = 1'b1;
      free_at[d] = c + VW + nd + 1;
    end
  endtask

  // Reset sampled at the end of cycle r cancels everything scheduled after it.
  task automatic model_reset(int r);
    int ks [$];
    foreach (m_busy[k]) if (k / 2 > r) ks.push_back(k);
    foreach (m_done[k]) if (k / 2 > r) ks.push_back(k);
    foreach (m_data[k]) if (k / 2 > r) ks.push_back(k);
    foreach (ks[j]) begin
      if (m_busy.exists(ks[j])) m_busy.delete(ks[j]);
      if (m_done.exists(ks[j])) m_done.delete(ks[j]);
      if (m_data.exists(ks[j])) m_data.delete(ks[j]);
      if (m_addr.exists(ks[j])) m_addr.delete(ks[j]);
    end
    free_at[0] = r + 1;
    free_at[1] = r + 1;
  endtask

  task automatic check_dut(int d, int busy, int done, int wr_en, int addr, int data);
    int k;
    bit ew;
    k  = key(d, cyc);
    ew = m_data.exists(k);
    chk($sformatf("dut%0d busy @%0d", d, cyc), busy, int'(m_busy.exists(k)));
    chk($sformatf("dut%0d done @%0d", d, cyc), done, int'(m_done.exists(k)));
    chk($sformatf("dut%0d wr_en @%0d", d, cyc), wr_en, int'(ew));
    if (ew) begin
      chk($sformatf("dut%0d wr_addr @%0d", d, cyc), addr, m_addr[k]);
      chk($sformatf("dut%0d wr_data @%0d", d, cyc), data, m_data[k]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, int'(bus4.busy), int'(bus4.done), int'(bus4.wr_en),
                int'(bus4.wr_addr), int'(bus4.wr_data));
      check_dut(1, int'(bus3.busy), int'(bus3.done), int'(bus3.wr_en),
                int'(bus3.wr_addr), int'(bus3.wr_data));
      if (bus4.wr_en) begin
        log4.push_back(int'(bus4.wr_data));
        wcyc4.push_back(cyc);
      end
      if (bus4.done) begin
        done_cyc4 = cyc;
        ndone4++;
      end
      if (bus4.busy) nbusy4++;
      if (bus3.wr_en) log3.push_back(int'(bus3.wr_data));
    end
  end

  task automatic drive(bit rst, bit st4, int v4, bit st3, int v3);
    @(posedge clk);
    #1;
    rst_n      = rst;
    bus4.start = st4;
    bus4.value = VW'(v4);
    bus3.start = st3;
    bus3.value = VW'(v3);
    if (!rst) begin
      model_reset(cyc);
    end else begin
      model_accept(0, st4, v4);
      model_accept(1, st3, v3);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  // Pops the oldest nd logged codes of a dut and compares them to literals.
  task automatic chk_log(string name, int d, int e0, int e1, int e2, int e3);
    int e [4];
    int nd, got;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    nd = (d == 0) ? 4 : 3;
    for (int i = 0; i < nd; i++) begin
      if (d == 0) got = (log4.size() > 0) ? log4.pop_front() : -1;
      else        got = (log3.size() > 0) ? log3.pop_front() : -1;
      chk($sformatf("%s cell%0d", name, i), got, e[i]);
    end
  endtask

  task automatic clear_logs();
    log4.delete();
    wcyc4.delete();
    log3.delete();
    done_cyc4 = -1;
    ndone4 = 0;
    nbusy4 = 0;
  endtask

  task automatic conv4(int v);
    drive(1'b1, 1'b1, v, 1'b0, 0);
    idle(VW + 4 + 2);
  endtask

  task automatic conv3(int v);
    drive(1'b1, 1'b0, 0, 1'b1, v);
    idle(VW + 3 + 2);
  endtask

  int t0;

  initial begin
    rst_n      = 1'b0;
    bus4.start = 1'b0;
    bus4.value = '0;
    bus3.start = 1'b0;
    bus3.value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy4", int'(bus4.busy), 0);
    chk("reset done4", int'(bus4.done), 0);
    chk("reset wr_en4", int'(bus4.wr_en), 0);
    chk("reset wr_addr4", int'(bus4.wr_addr), 0);
    chk("reset wr_data4", int'(bus4.wr_data), 0);
    chk("reset wr_en3", int'(bus3.wr_en), 0);
    chk("reset busy3", int'(bus3.busy), 0);
    rst_n      = 1'b1;
    free_at[0] = cyc;
    free_at[1] = cyc;
    chk_en     = 1'b1;

    // value 0: only the last cell shows a digit; latency pinned by hand
    clear_logs();
    drive(1'b1, 1'b1, 0, 1'b0, 0);
    t0 = cyc;
    idle(VW + 4 + 2);
    chk("v0 first write latency", (wcyc4.size() > 0) ? wcyc4[0] - t0 : -1, 11);
    chk("v0 done latency", done_cyc4 - t0, 15);
    chk("v0 done pulses", ndone4, 1);
    chk_log("v0", 0, 255, 255, 255, 0);

    // full-scale value
    clear_logs();
    conv4(1023);
    chk("v1023 busy cycles", nbusy4, 14);
    chk_log("v1023", 0, 1, 0, 2, 3);

    // 705 with an ignored start at T+5, then back-to-back 40 started in the done cycle
    clear_logs();
    drive(1'b1, 1'b1, 705, 1'b0, 0);
    idle(4);
    drive(1'b1, 1'b1, 999, 1'b0, 0);
    idle(9);
    drive(1'b1, 1'b1, 40, 1'b0, 0);
    idle(VW + 4 + 2);
    chk("705/40 done pulses", ndone4, 2);
    chk_log("v705", 0, 255, 7, 0, 5);
    chk_log("v40", 0, 255, 255, 4, 0);

    // reset during the write phase of 1023: only cells 0 and 1 get written
    clear_logs();
    drive(1'b1, 1'b1, 1023, 1'b0, 0);
    idle(11);
    drive(1'b0, 1'b0, 0, 1'b0, 0);
    idle(6);
    chk("reset-abort write count", log4.size(), 2);
    chk("reset-abort done pulses", ndone4, 0);
    chk("reset-abort busy4", int'(bus4.busy), 0);
    clear_logs();
    conv4(512);
    chk_log("v512 after reset", 0, 255, 5, 1, 2);

    clear_logs();
    conv4(9);
    conv4(100);
    conv4(1000);
    chk_log("v9", 0, 255, 255, 255, 9);
    chk_log("v100", 0, 255, 1, 0, 0);
    chk_log("v1000", 0, 1, 0, 0, 0);

    // three-cell instance: overflow, largest fit, leading blanks
    clear_logs();
    conv3(1000);
    conv3(999);
    conv3(7);
    conv3(0);
    conv3(1023);
    chk_log("d3 v1000", 1, 254, 254, 254, 0);
    chk_log("d3 v999", 1, 9, 9, 9, 0);
    chk_log("d3 v7", 1, 255, 255, 7, 0);
    chk_log("d3 v0", 1, 255, 255, 0, 0);
    chk_log("d3 v1023", 1, 254, 254, 254, 0);

    idle(3);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
